cpu_sram_arbiter: RTL
=====================

Name: cpu_sram_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data-access requester of the 5-stage CPU.
- Selects one request per cycle. Data has priority; a starvation limit guarantees instruction fetches still make progress.
- Tracks in-flight transactions in order and routes each data_ok/rdata back to the requester that issued it.
- Sits between the CPU core and the memory/bridge side.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (1..4).
- STARVE_LIMIT, 4, consecutive data grants taken while inst_req is pending before inst is forced through (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction read request.
- inst_addr  in  32  instruction address (word-aligned).
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction read data valid this cycle.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  data address.
- data_wdata  in  32  write data.
- data_wstrb  in  4  byte write strobes.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data read data / write ack valid this cycle.
- data_rdata  out  32  data read data.
- mem_req  out  1  downstream request.
- mem_wr  out  1  downstream write.
- mem_size  out  2  downstream size.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_wstrb  out  4  downstream strobes.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response valid.
- mem_rdata  in  32  downstream read data.
- busy  out  1  at least one transaction outstanding.
- err  out  1  sticky: mem_data_ok arrived with nothing outstanding.

Behaviour:
- Protocol rules
  - A requester holds req and all request fields stable until it sees its addr_ok.
  - A handshake occurs when mem_req && mem_addr_ok.
  - mem_data_ok for a transaction arrives at the earliest 1 cycle after its handshake.
  - Responses return in issue order.
- State
  - cnt: 0..OUTSTANDING.
  - Owner FIFO, depth OUTSTANDING, 1 bit per entry (0 = inst, 1 = data).
  - lock_valid, lock_owner.
  - starve_cnt (4 bits).
  - err.
- Reset (async, active-high): cnt = 0, FIFO empty, lock_valid = 0, starve_cnt = 0, err = 0. While reset is high, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok and busy are all 0.
- Reset mid-operation: all in-flight tracking is dropped. Responses arriving after reset release hit the empty FIFO and set err.
- full = (cnt == OUTSTANDING).
- mem_req = !full && (inst_req || data_req).
- Grant (combinational), in priority order:
  - lock_valid: grant lock_owner.
  - Otherwise, starve_cnt == STARVE_LIMIT && inst_req: grant inst.
  - Otherwise, data_req: grant data.
  - Otherwise: grant inst.
- Lock: set to the current grant when mem_req && !mem_addr_ok. Cleared on the handshake. Holds the selection stable across downstream backpressure.
- Mux
  - Data grant: data fields pass through unchanged.
  - Inst grant: mem_wr = 0, mem_size = 2, mem_addr = inst_addr, mem_wdata = 0, mem_wstrb = 0.
- Accept acknowledgements:
  - inst_addr_ok = handshake && grant == inst.
  - data_addr_ok = handshake && grant == data.
  - Zero-cycle combinational path from mem_addr_ok.
- Handshake: push the grant into the owner FIFO.
- mem_data_ok with cnt > 0:
  - Pop the head.
  - inst_data_ok = head == inst; data_data_ok = head == data.
  - Both rdata outputs = mem_rdata unconditionally.
- mem_data_ok with cnt == 0: no ok output, err <= 1 (sticky until reset).
- Simultaneous push and pop: cnt unchanged, FIFO order preserved.
- Full: mem_req = 0 even when a pop occurs in the same cycle; the gate uses registered cnt.
- starve_cnt
  - +1 (saturating at STARVE_LIMIT) on a data handshake while inst_req = 1.
  - Cleared on an inst handshake, or whenever inst_req = 0.
- busy = (cnt != 0).
- Latency: arbitration adds 0 cycles on both the request and response paths.

Test Plan:
- Inst only, mem_addr_ok tied 1, data_ok 1 cycle later, addr 0xBFC00000: inst_addr_ok in cycle 0, mem_addr = 0xBFC00000, mem_size = 2, inst_data_ok + rdata in cycle 1, data_data_ok stays 0.
- inst_req and data_req held continuously, STARVE_LIMIT = 4: grant order D, D, D, D, I, D, D, D, D, I; starve_cnt returns to 0 after each I.
- Data write 0x12345678, wstrb 4'b0011, mem_addr_ok held 0 for 3 cycles while inst_req rises: mem_* fields stay on the data write for all 3 cycles; data_addr_ok fires only when mem_addr_ok = 1; inst waits.
- OUTSTANDING = 2, two inst handshakes with no responses: third request sees mem_req = 0 and busy = 1. A data_ok in the next cycle pops the head to inst; mem_req reasserts the following cycle.
- Issue I then D, responses return in order with rdata 0xAAAA0000 then 0x5555FFFF: inst_data_ok with 0xAAAA0000, then data_data_ok with 0x5555FFFF.
- reset pulsed with 2 outstanding, then mem_data_ok after release: no ok outputs assert, err = 1, cnt = 0.

Source files
------------

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like port between the CPU instruction-fetch and data requesters.
// Data has priority, a starvation counter forces fetches through, and responses are routed in order.
module cpu_sram_arbiter #(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned ST_W  = 4;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [CNT_W-1:0]       r_cnt;
  logic [OUTSTANDING-1:0] r_fifo;
  logic                   r_lock_valid;
  logic                   r_lock_owner;
  logic [ST_W-1:0]        r_starve;
  logic                   r_err;

  logic                   w_full;
  logic                   w_starved;
  logic                   w_grant;
  logic                   w_mem_req;
  logic                   w_hs;
  logic                   w_resp;
  logic                   w_head;
  logic [CNT_W-1:0]       w_wr_idx;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [OUTSTANDING-1:0] w_fifo_nxt;

  assign w_full    = (r_cnt == CNT_W'(OUTSTANDING));
  assign w_starved = (r_starve == ST_W'(STARVE_LIMIT));
  assign w_mem_req = !reset && !w_full && (inst_req || data_req);
  assign w_hs      = w_mem_req && mem_addr_ok;
  assign w_resp    = !reset && mem_data_ok && (r_cnt != '0);
  assign w_head    = r_fifo[0];

  // Grant: held lock, then forced fetch on starvation, then data priority.
  always_comb begin
    w_grant = OWN_INST;
    if (r_lock_valid) begin
      w_grant = r_lock_owner;
    end else if (w_starved && inst_req) begin
      w_grant = OWN_INST;
    end else if (data_req) begin
      w_grant = OWN_DATA;
    end
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd2;
    mem_addr  = inst_addr;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (w_grant == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wstrb = data_wstrb;
    end
  end

  assign mem_req      = w_mem_req;
  assign inst_addr_ok = w_hs && (w_grant == OWN_INST);
  assign data_addr_ok = w_hs && (w_grant == OWN_DATA);
  assign inst_data_ok = w_resp && (w_head == OWN_INST);
  assign data_data_ok = w_resp && (w_head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = (r_cnt != '0);
  assign err          = r_err;

  // Owner FIFO kept head-at-bit-0; a pop shifts down before the push slot is chosen.
  always_comb begin
    w_fifo_nxt = w_resp ? (r_fifo >> 1) : r_fifo;
    w_wr_idx   = w_resp ? (r_cnt - CNT_W'(1)) : r_cnt;
    for (int unsigned i = 0; i < OUTSTANDING; i++) begin
      if (w_hs && (CNT_W'(i) == w_wr_idx)) begin
        w_fifo_nxt[i] = w_grant;
      end
    end
    w_cnt_nxt = r_cnt + CNT_W'(w_hs) - CNT_W'(w_resp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_fifo <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_fifo <= w_fifo_nxt;
    end
  end

  // Lock keeps the selection stable while the downstream side stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= OWN_INST;
    end else if (w_hs) begin
      r_lock_valid <= 1'b0;
    end else if (w_mem_req) begin
      r_lock_valid <= 1'b1;
      r_lock_owner <= w_grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!inst_req) begin
      r_starve <= '0;
    end else if (w_hs && (w_grant == OWN_INST)) begin
      r_starve <= '0;
    end else if (w_hs && (w_grant == OWN_DATA) && !w_starved) begin
      r_starve <= r_starve + ST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (mem_data_ok && (r_cnt == '0)) begin
      r_err <= 1'b1;
    end
  end

endmodule
